// File: rtl/bnn_layer_sequencer.sv
// bnn_layer_sequencer: top-level control FSM for the BNN inference datapath.
// Runs one image load followed by NUM_LAYERS layers, handshaking each stage with a start pulse and a done.
module bnn_layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter int TIMEOUT    = 0,
    parameter int CNT_W      = 16,
    parameter int STATE_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  repeat_en,
    input  logic                  abort,
    input  logic                  load_done,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  load_start,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic [STATE_W-1:0]    state,
    output logic                  busy,
    output logic                  infer_done,
    output logic                  timeout_err,
    output logic [CNT_W-1:0]      stage_cycles
);

    localparam logic [STATE_W-1:0] S_IDLE   = '0;
    localparam logic [STATE_W-1:0] S_LOAD   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_LAYER0 = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_DONE   = STATE_W'(NUM_LAYERS + 2);

    localparam bit               TIMEOUT_ON   = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    logic [STATE_W-1:0]    state_q;
    logic [STATE_W-1:0]    state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [NUM_LAYERS-1:0] layer_sel;
    logic [NUM_LAYERS-1:0] layer_start_d;
    logic                  in_stage;
    logic                  entry_cycle;
    logic                  stage_done;
    logic                  done_accept;
    logic                  timeout_hit;
    logic                  state_change;
    logic                  err_d;
    logic                  load_start_d;
    logic                  busy_d;
    logic                  infer_done_d;

    // The counter saturates instead of wrapping, so zero inside a stage only ever marks its entry cycle.
    always_comb begin
        layer_sel = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            layer_sel[k] = (state_q == STATE_W'(k + 2));
        end
        in_stage    = (state_q == S_LOAD) || (|layer_sel);
        entry_cycle = (cnt_q == '0);
        stage_done  = ((state_q == S_LOAD) && load_done) || (|(layer_sel & layer_done));
        done_accept = in_stage && stage_done && !entry_cycle;
        timeout_hit = TIMEOUT_ON && in_stage && (cnt_q == TIMEOUT_LAST) && !done_accept;
    end

    always_comb begin
        state_d = state_q;
        err_d   = timeout_err;
        if (state_q == S_IDLE) begin
            if (mode) begin
                state_d = S_LOAD;
                err_d   = 1'b0;
            end
        end else if (abort) begin
            state_d = S_IDLE;
        end else if (state_q == S_DONE) begin
            state_d = (repeat_en && mode) ? S_LOAD : S_IDLE;
        end else if (in_stage) begin
            if (done_accept) begin
                state_d = state_q + 1'b1;
            end else if (timeout_hit) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    // Outputs are decoded from the next state so they register in step with the state itself.
    always_comb begin
        state_change  = (state_d != state_q);
        load_start_d  = (state_d == S_LOAD) && state_change;
        layer_start_d = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            layer_start_d[k] = (state_d == STATE_W'(k + 2)) && state_change;
        end
        busy_d       = (state_d == S_LOAD) || ((state_d >= S_LAYER0) && (state_d < S_DONE));
        infer_done_d = (state_d == S_DONE);
        if (state_change || !in_stage) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            timeout_err <= 1'b0;
            load_start  <= 1'b0;
            layer_start <= '0;
            busy        <= 1'b0;
            infer_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            timeout_err <= err_d;
            load_start  <= load_start_d;
            layer_start <= layer_start_d;
            busy        <= busy_d;
            infer_done  <= infer_done_d;
        end
    end

    assign state        = state_q;
    assign stage_cycles = cnt_q;

endmodule
